clock_set_ctrl: RTL and testbench
=================================

# clock_set_ctrl

Time-set controller for the HH:MM:SS clock. It sequences the timekeeper between running and user editing, driven by two debounced push-buttons (mode, increment). It owns the edit copy of hours and minutes and the display source mux, and issues a one-cycle load to the timekeeper on commit. It sits between the button inputs and the seconds/minutes/hours counter, ahead of the seven-segment decoders.

## Interface
- CLK_HZ, 50_000_000: clk frequency; informational, used only to derive the other defaults.
- HOLD_CYCLES, CLK_HZ/2: cycles inc must be held before auto-repeat starts.
- REPEAT_CYCLES, CLK_HZ/8: auto-repeat period while inc stays held.
- BLINK_CYCLES, CLK_HZ/4: half-period of the edited-field blink.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- btn_mode  in  1  debounced mode button, asynchronous level, 1 = pressed.
- btn_inc  in  1  debounced increment button, asynchronous level, 1 = pressed.
- cur_hour / cur_min / cur_sec  in  5/6/6  live time from the timekeeper.
- run_en  out  1  timekeeper count enable.
- load  out  1  one-cycle pulse that loads load_hour/load_min/load_sec into the timekeeper.
- load_hour / load_min / load_sec  out  5/6/6  load values; 0 when load=0.
- disp_hour / disp_min / disp_sec  out  5/6/6  values to display.
- blank_mask  out  6  per-digit blank. Bit0/1 = sec ones/tens, bit2/3 = min ones/tens, bit4/5 = hour ones/tens.
- mode  out  2  current state: RUN=0, SET_HOUR=1, SET_MIN=2, COMMIT=3.

## Operation
- Both buttons pass through a 2-flop synchronizer and rising-edge detect. Each produces a one-cycle press event and a synchronized held level.
- FSM transitions:
  - RUN: mode press copies cur_hour/cur_min into edit_hour/edit_min and goes to SET_HOUR.
  - SET_HOUR: mode press goes to SET_MIN.
  - SET_MIN: mode press goes to COMMIT.
  - COMMIT: lasts exactly one cycle with load=1, load_hour=edit_hour, load_min=edit_min, load_sec=0. Then goes to RUN.
- run_en is 1 only in RUN. Time is frozen from the SET_HOUR entry until the load.
- Increment in SET_HOUR: edit_hour+1, wrapping 23 to 0. In SET_MIN: edit_min+1, wrapping 59 to 0. Ignored in RUN and COMMIT.
- Auto-repeat (SET states only):
  - A press increments once.
  - If inc stays held, another increment follows HOLD_CYCLES cycles after the press, then one every REPEAT_CYCLES.
  - Releasing inc or a mode press clears the repeat counter.
- Display source:
  - RUN: disp = cur.
  - SET states and COMMIT: disp_hour=edit_hour, disp_min=edit_min, disp_sec=0.
- Blink:
  - The counter runs only in SET states; the phase toggles every BLINK_CYCLES.
  - Phase 1 blanks the edited field: bits 5:4 in SET_HOUR, bits 3:2 in SET_MIN. All other bits are 0.
  - Entering a SET state, and any increment, clears the counter and sets phase 0 (visible).
- Simultaneous mode and inc press in the same cycle: mode wins and the increment is dropped.
- Arithmetic is unsigned. Edit registers never hold out-of-range values. cur_* inputs are trusted to be in range.

## Timing
- Reset (asynchronous, any state): state=RUN, run_en=1, load=0, load_*=0, blank_mask=0, edit regs=0, all counters and sync flops=0, disp=cur. Reset mid-edit discards the edit without issuing a load.
- Press latency: with the input first sampled high at edge N, the state or edit register changes at edge N+2.
- load is high for exactly one cycle, two edges after the SET_MIN mode press is registered. run_en rises the same edge load falls.
- disp_*, blank_mask and run_en are registered or decoded from registered state. No combinational path from btn_* to any output.
- Auto-repeat increments occur at the press edge E, then at E+HOLD_CYCLES, then every REPEAT_CYCLES while held.

## Structure
- clock_pkg holds: the mode enum (RUN, SET_HOUR, SET_MIN, COMMIT), MAX_HOUR=23, MAX_MIN=59, HOUR_W=5, MIN_W=6, SEC_W=6, and the blank_mask bit positions. The timekeeper and display decoders share this package.
- Sub-module btn_sync_edge: 2-flop synchronizer plus edge detect, outputs level and press. Instantiated twice.
- Top contains: FSM, edit registers, repeat counter, blink counter, output mux.

## Test plan
Bench parameters: HOLD_CYCLES=8, REPEAT_CYCLES=4, BLINK_CYCLES=5.
- Reset, then cur=12:34:56 with no presses -> mode=0, run_en=1, load=0, disp=12:34:56, blank_mask=0.
- cur=12:34:56; mode press; 13 inc presses; mode; 27 inc presses; mode -> single load pulse with 01:01:00 (12+13 wraps, 34+27 wraps). run_en=0 from the SET_HOUR entry until load falls.
- In SET_HOUR, edit=22, hold inc for 20 cycles -> increments at E, E+8, E+12, E+16, E+20. edit=22,23,0,1,2,3.
- In SET_MIN, mode and inc pressed in the same cycle -> COMMIT, edit_min unchanged, load asserted once.
- In SET_HOUR with no presses -> blank_mask toggles between 0 and 6'b110000 every 5 cycles, starting visible. An inc press returns it to 0 immediately.
- Assert reset in SET_MIN after edits -> immediate RUN, run_en=1, no load pulse, edit regs=0.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared types and constants for the HH:MM:SS clock: mode encoding, field
// widths and limits, and the per-digit blank_mask layout.
package clock_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2,
        COMMIT   = 2'd3
    } mode_t;

    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;
    localparam int SEC_W  = 6;

    localparam logic [HOUR_W-1:0] MAX_HOUR = 5'd23;
    localparam logic [MIN_W-1:0]  MAX_MIN  = 6'd59;

    localparam int BLANK_W         = 6;
    localparam int BLANK_SEC_ONES  = 0;
    localparam int BLANK_SEC_TENS  = 1;
    localparam int BLANK_MIN_ONES  = 2;
    localparam int BLANK_MIN_TENS  = 3;
    localparam int BLANK_HOUR_ONES = 4;
    localparam int BLANK_HOUR_TENS = 5;

    localparam logic [BLANK_W-1:0] BLANK_HOUR_FIELD =
        (6'b1 << BLANK_HOUR_ONES) | (6'b1 << BLANK_HOUR_TENS);
    localparam logic [BLANK_W-1:0] BLANK_MIN_FIELD =
        (6'b1 << BLANK_MIN_ONES) | (6'b1 << BLANK_MIN_TENS);

    function automatic logic [HOUR_W-1:0] next_hour(input logic [HOUR_W-1:0] h);
        return (h >= MAX_HOUR) ? '0 : h + HOUR_W'(1);
    endfunction

    function automatic logic [MIN_W-1:0] next_min(input logic [MIN_W-1:0] m);
        return (m >= MAX_MIN) ? '0 : m + MIN_W'(1);
    endfunction

endpackage

// File: rtl/clock_set_ctrl_btn_sync_edge.sv
// Two-flop synchronizer for a debounced button plus rising-edge detect;
// press is a one-cycle pulse, level is the synchronized button state.
module btn_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic level,
    output logic press
);

    logic [2:0] sync_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[1:0], btn};
        end
    end

    assign level = sync_reg[1];
    assign press = sync_reg[1] & ~sync_reg[2];

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-set controller: sequences the timekeeper between running and editing
// hours/minutes, with increment auto-repeat, field blink and a commit load pulse.
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int CLK_HZ        = 50_000_000,
    parameter int HOLD_CYCLES   = CLK_HZ / 2,
    parameter int REPEAT_CYCLES = CLK_HZ / 8,
    parameter int BLINK_CYCLES  = CLK_HZ / 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_mode,
    input  logic              btn_inc,
    input  logic [HOUR_W-1:0] cur_hour,
    input  logic [MIN_W-1:0]  cur_min,
    input  logic [SEC_W-1:0]  cur_sec,
    output logic              run_en,
    output logic              load,
    output logic [HOUR_W-1:0] load_hour,
    output logic [MIN_W-1:0]  load_min,
    output logic [SEC_W-1:0]  load_sec,
    output logic [HOUR_W-1:0] disp_hour,
    output logic [MIN_W-1:0]  disp_min,
    output logic [SEC_W-1:0]  disp_sec,
    output logic [BLANK_W-1:0] blank_mask,
    output logic [1:0]        mode
);

    localparam int RPT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);
    localparam int BLINK_W = $clog2(BLINK_CYCLES + 1);
    localparam logic [RPT_W-1:0]   HOLD_CNT   = RPT_W'(HOLD_CYCLES);
    localparam logic [RPT_W-1:0]   REPEAT_CNT = RPT_W'(REPEAT_CYCLES);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);
    localparam int BTN_MODE = 0;
    localparam int BTN_INC  = 1;

    logic [1:0] btn_raw, btn_level, btn_press;
    assign btn_raw = {btn_inc, btn_mode};

    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
        btn_sync_edge u_sync (
            .clk   (clk),
            .reset (reset),
            .btn   (btn_raw[gi]),
            .level (btn_level[gi]),
            .press (btn_press[gi])
        );
    end

    logic mode_press, inc_press, inc_level, unused_mode_level;
    assign mode_press        = btn_press[BTN_MODE];
    assign inc_press         = btn_press[BTN_INC];
    assign inc_level         = btn_level[BTN_INC];
    assign unused_mode_level = btn_level[BTN_MODE];

    mode_t              state_reg, state_next;
    logic [HOUR_W-1:0]  edit_hour_reg;
    logic [MIN_W-1:0]   edit_min_reg;
    logic [RPT_W-1:0]   rpt_cnt_reg;
    logic               rpt_active_reg;
    logic [BLINK_W-1:0] blink_cnt_reg;
    logic               blink_phase_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            RUN:      if (mode_press) state_next = SET_HOUR;
            SET_HOUR: if (mode_press) state_next = SET_MIN;
            SET_MIN:  if (mode_press) state_next = COMMIT;
            COMMIT:   state_next = RUN;
            default:  state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_reg <= RUN;
        else       state_reg <= state_next;
    end

    logic in_set, rpt_due, inc_fire, enter_set;
    assign in_set    = (state_reg == SET_HOUR) || (state_reg == SET_MIN);
    // A zero count means no press is being tracked, so a held button only repeats after a fresh press.
    assign rpt_due   = inc_level && (rpt_cnt_reg != '0) &&
                       (rpt_cnt_reg == (rpt_active_reg ? REPEAT_CNT : HOLD_CNT));
    assign inc_fire  = in_set && !mode_press && (inc_press || rpt_due);
    assign enter_set = (state_next != state_reg) &&
                       ((state_next == SET_HOUR) || (state_next == SET_MIN));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            edit_hour_reg <= '0;
            edit_min_reg  <= '0;
        end else if ((state_reg == RUN) && mode_press) begin
            edit_hour_reg <= cur_hour;
            edit_min_reg  <= cur_min;
        end else if (inc_fire) begin
            if (state_reg == SET_HOUR) edit_hour_reg <= next_hour(edit_hour_reg);
            else                       edit_min_reg  <= next_min(edit_min_reg);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rpt_cnt_reg    <= '0;
            rpt_active_reg <= 1'b0;
        end else if (!in_set || mode_press || !inc_level) begin
            rpt_cnt_reg    <= '0;
            rpt_active_reg <= 1'b0;
        end else if (inc_fire) begin
            rpt_cnt_reg    <= RPT_W'(1);
            rpt_active_reg <= !inc_press;
        end else if (rpt_cnt_reg != '0) begin
            rpt_cnt_reg    <= rpt_cnt_reg + RPT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt_reg   <= '0;
            blink_phase_reg <= 1'b0;
        end else if (!in_set || enter_set || inc_fire) begin
            blink_cnt_reg   <= '0;
            blink_phase_reg <= 1'b0;
        end else if (blink_cnt_reg == BLINK_LAST) begin
            blink_cnt_reg   <= '0;
            blink_phase_reg <= ~blink_phase_reg;
        end else begin
            blink_cnt_reg   <= blink_cnt_reg + BLINK_W'(1);
        end
    end

    always_comb begin
        blank_mask = '0;
        if (blink_phase_reg) begin
            if (state_reg == SET_HOUR)     blank_mask = BLANK_HOUR_FIELD;
            else if (state_reg == SET_MIN) blank_mask = BLANK_MIN_FIELD;
        end
    end

    assign mode      = state_reg;
    assign run_en    = (state_reg == RUN);
    assign load      = (state_reg == COMMIT);
    assign load_hour = load ? edit_hour_reg : '0;
    assign load_min  = load ? edit_min_reg : '0;
    assign load_sec  = '0;
    assign disp_hour = run_en ? cur_hour : edit_hour_reg;
    assign disp_min  = run_en ? cur_min  : edit_min_reg;
    assign disp_sec  = run_en ? cur_sec  : '0;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: directed scenarios plus random button traffic,
// checked against a transaction-level model of the edit/commit rules.
module tb_clock_set_ctrl;

    localparam int HOLD  = 8;
    localparam int REP   = 4;
    localparam int BLINK = 5;

    logic       clk = 1'b0, reset = 1'b1, btn_mode = 1'b0, btn_inc = 1'b0;
    logic [4:0] cur_hour, load_hour, disp_hour;
    logic [5:0] cur_min, cur_sec, load_min, load_sec, disp_min, disp_sec, blank_mask;
    logic       run_en, load;
    logic [1:0] mode;

    int n_total = 0, n_pass = 0;
    int exp_mode = 0, eh = 0, em = 0, exp_loads = 0;
    int load_pulses = 0, load_cycles = 0, viol = 0;
    logic load_prev = 1'b0;

    always #5 clk = ~clk;

    clock_set_ctrl #(
        .CLK_HZ(1000), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP), .BLINK_CYCLES(BLINK)
    ) dut (
        .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
        .run_en(run_en), .load(load), .load_hour(load_hour), .load_min(load_min),
        .load_sec(load_sec), .disp_hour(disp_hour), .disp_min(disp_min),
        .disp_sec(disp_sec), .blank_mask(blank_mask), .mode(mode)
    );

    // Passive watch on the load pulse and the run_en/mode relationship.
    always @(negedge clk) begin
        if (!reset) begin
            if (load) load_cycles++;
            if (load && !load_prev) load_pulses++;
            if (!load && (load_hour != 0 || load_min != 0 || load_sec != 0)) viol++;
            if (run_en !== (mode == 2'd0)) viol++;
        end
        load_prev = load;
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    endtask

    task automatic press(input logic m, input logic i);
        btn_mode = m;
        btn_inc  = i;
        tick(3);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
    endtask

    task automatic chk_disp(input string tag);
        if (exp_mode == 0) begin
            chk({tag, "_dh"}, 32'(disp_hour), 32'(cur_hour));
            chk({tag, "_dm"}, 32'(disp_min), 32'(cur_min));
            chk({tag, "_ds"}, 32'(disp_sec), 32'(cur_sec));
        end else begin
            chk({tag, "_dh"}, 32'(disp_hour), eh);
            chk({tag, "_dm"}, 32'(disp_min), em);
            chk({tag, "_ds"}, 32'(disp_sec), 0);
        end
    endtask

    task automatic do_mode(input string tag);
        press(1'b1, 1'b0);
        case (exp_mode)
            0: begin eh = int'(cur_hour); em = int'(cur_min); exp_mode = 1; end
            1: exp_mode = 2;
            default: exp_mode = 3;
        endcase
        chk({tag, "_mode"}, 32'(mode), exp_mode);
        chk({tag, "_run"}, 32'(run_en), (exp_mode == 0) ? 1 : 0);
        chk_disp(tag);
        if (exp_mode == 3) begin
            chk({tag, "_load"}, 32'(load), 1);
            chk({tag, "_lh"}, 32'(load_hour), eh);
            chk({tag, "_lm"}, 32'(load_min), em);
            chk({tag, "_ls"}, 32'(load_sec), 0);
            exp_loads++;
            tick();
            exp_mode = 0;
            chk({tag, "_mode_after"}, 32'(mode), 0);
            chk({tag, "_load_after"}, 32'(load), 0);
            chk({tag, "_run_after"}, 32'(run_en), 1);
        end
        tick(2);
    endtask

    task automatic do_inc(input string tag);
        press(1'b0, 1'b1);
        if (exp_mode == 1) eh = (eh + 1) % 24;
        if (exp_mode == 2) em = (em + 1) % 60;
        chk({tag, "_mode"}, 32'(mode), exp_mode);
        chk_disp(tag);
        tick(2);
    endtask

    initial begin
        cur_hour = 5'd12; cur_min = 6'd34; cur_sec = 6'd56;

        // Reset state, while held and after release.
        tick(3);
        chk("rst_mode", 32'(mode), 0);
        chk("rst_run", 32'(run_en), 1);
        chk("rst_load", 32'(load), 0);
        chk("rst_blank", 32'(blank_mask), 0);
        chk_disp("rst");
        reset = 1'b0;
        tick(3);
        chk("idle_mode", 32'(mode), 0);
        chk("idle_load", 32'(load), 0);
        chk("idle_blank", 32'(blank_mask), 0);
        chk_disp("idle");

        // Full edit with wraps: 12+13 -> 1, 34+27 -> 1.
        do_mode("e1_enter");
        for (int i = 0; i < 13; i++) do_inc("e1_hinc");
        do_mode("e1_min");
        for (int i = 0; i < 27; i++) do_inc("e1_minc");
        do_mode("e1_commit");

        // Blink in SET_HOUR, cycle-exact from the entry edge.
        cur_hour = 5'd21; cur_min = 6'd10;
        do_mode("bl_enter");
        for (int k = 2; k < 12; k++) begin
            chk("blink", 32'(blank_mask), ((k / BLINK) % 2 == 1) ? 32'h30 : 32'h0);
            tick();
        end
        tick(4);
        chk("blink_k16", 32'(blank_mask), 32'h30);
        btn_inc = 1'b1;
        tick(2);
        chk("blink_k18", 32'(blank_mask), 32'h30);
        tick();
        eh = (eh + 1) % 24;
        chk("blink_inc_clr", 32'(blank_mask), 0);
        chk("blink_inc_h", 32'(disp_hour), eh);
        btn_inc = 1'b0;
        tick(2);

        // Auto-repeat from 22: increments at E, E+8, E+12, E+16, E+20.
        btn_inc = 1'b1;
        tick(2);
        chk("rpt_latency", 32'(disp_hour), eh);
        tick();
        eh = (eh + 1) % 24;
        chk("rpt_E", 32'(disp_hour), eh);
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k >= HOLD && (k - HOLD) % REP == 0) eh = (eh + 1) % 24;
            chk("rpt_hold", 32'(disp_hour), eh);
        end
        btn_inc = 1'b0;
        tick(6);
        chk("rpt_release", 32'(disp_hour), eh);
        chk("rpt_final", 32'(disp_hour), 3);

        // Simultaneous mode+inc in SET_MIN: mode wins.
        do_mode("sim_min");
        do_inc("sim_minc");
        press(1'b1, 1'b1);
        chk("sim_mode", 32'(mode), 3);
        chk("sim_load", 32'(load), 1);
        chk("sim_lm", 32'(load_min), em);
        chk("sim_lh", 32'(load_hour), eh);
        chk("sim_dm", 32'(disp_min), em);
        exp_loads++;
        tick();
        exp_mode = 0;
        chk("sim_run", 32'(mode), 0);
        chk("sim_load_off", 32'(load), 0);
        tick(2);

        // Random button traffic with random live time.
        for (int i = 0; i < 60; i++) begin
            cur_hour = 5'($urandom_range(0, 23));
            cur_min  = 6'($urandom_range(0, 59));
            cur_sec  = 6'($urandom_range(0, 59));
            if ($urandom_range(0, 2) == 0) do_mode("rnd_mode");
            else                           do_inc("rnd_inc");
        end
        while (exp_mode != 0) do_mode("rnd_exit");

        // Asynchronous reset mid-edit discards the edit without a load.
        cur_hour = 5'd5; cur_min = 6'd6; cur_sec = 6'd7;
        do_mode("ra_enter");
        do_inc("ra_h");
        do_mode("ra_min");
        do_inc("ra_m");
        do_inc("ra_m");
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        exp_mode = 0;
        chk("ra_mode", 32'(mode), 0);
        chk("ra_run", 32'(run_en), 1);
        chk("ra_load", 32'(load), 0);
        chk("ra_blank", 32'(blank_mask), 0);
        chk_disp("ra");
        chk("ra_edit_h", 32'(dut.edit_hour_reg), 0);
        chk("ra_edit_m", 32'(dut.edit_min_reg), 0);
        tick(2);
        reset = 1'b0;
        tick(3);
        chk("ra_post_mode", 32'(mode), 0);

        chk("load_pulses", load_pulses, exp_loads);
        chk("load_cycles", load_cycles, exp_loads);
        chk("monitor_viol", viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
